// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// register width, operation codes and sequencer state encodings.
package muldiv_seq_pkg;

    localparam int unsigned REG_WIDTH = 32;

    // Operation codes as presented on the op port
    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        MDS_IDLE = 2'b00,
        MDS_PREP = 2'b01,
        MDS_RUN  = 2'b10,
        MDS_FIX  = 2'b11
    } md_state_e;

    // Bit 1 of the op code selects divide, bit 0 selects signed
    function automatic logic md_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input md_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath (purely combinational).
//   div_i  : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i  : 2*WIDTH accumulator; multiply: {partial product, multiplier},
//            divide: low half holds dividend bits shifting into quotient
//   rem_i  : WIDTH+1 partial remainder (divide only)
//   opnd_i : multiplicand or divisor magnitude
//   acc_o, rem_o : updated accumulator and remainder
module muldiv_step
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned WIDTH = REG_WIDTH
) (
    input  logic                 div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH:0]       rem_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic [WIDTH:0]       rem_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set; the carry lands in bit WIDTH of sum.
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // Divide: bring in next dividend bit, then trial-subtract.
        // Borrow out of the top bit means the divisor did not fit.
        shifted = {rem_i, acc_i[WIDTH-1]};
        trial   = shifted - {2'b00, opnd_i};

        acc_o = acc_i;
        rem_o = rem_i;
        if (div_i) begin
            if (!trial[WIDTH+1]) begin
                rem_o = trial[WIDTH:0];
                acc_o = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                rem_o = shifted[WIDTH:0];
                acc_o = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Constant latency of WIDTH+2 clocks from the accepting edge to done.
//   clk, rst       : clock, synchronous active-high reset
//   start, op      : request and op code (accepted only when idle)
//   op_a, op_b     : operands, sampled on the accepting edge
//   hi_we, lo_we   : MTHI/MTLO enables (honoured only when idle)
//   wdata          : MTHI/MTLO data
//   busy, done, dz : in-flight flag, completion pulse, divide-by-zero flag
//   hi, lo         : architectural HI/LO
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned WIDTH = REG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_e          state_q, state_d;
    md_op_e             op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH:0]     step_rem;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rmd;
    logic               is_div;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .div_i  (is_div),
        .acc_i  (acc_q),
        .rem_i  (rem_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc),
        .rem_o  (step_rem)
    );

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        is_div  = md_is_div(op_q);
        // Magnitudes of the raw operands; 0x8000.. maps onto itself,
        // which is the correct unsigned magnitude.
        a_mag   = (md_is_signed(op_q) && a_q[WIDTH-1]) ? ('0 - a_q) : a_q;
        b_mag   = (md_is_signed(op_q) && b_q[WIDTH-1]) ? ('0 - b_q) : b_q;
        prod    = (sa_q ^ sb_q) ? ('0 - acc_q) : acc_q;
        quo     = (sa_q ^ sb_q) ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rmd     = sa_q ? ('0 - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];

        case (state_q)
            MDS_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d = MDS_PREP;
                    op_d    = md_op_e'(op);
                    a_d     = op_a;
                    b_d     = op_b;
                end
            end
            MDS_PREP: begin
                sa_d    = md_is_signed(op_q) & a_q[WIDTH-1];
                sb_d    = md_is_signed(op_q) & b_q[WIDTH-1];
                opnd_d  = is_div ? b_mag : a_mag;
                acc_d   = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                rem_d   = '0;
                cnt_d   = '0;
                state_d = MDS_RUN;
            end
            MDS_RUN: begin
                acc_d = step_acc;
                rem_d = step_rem;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MDS_FIX;
            end
            MDS_FIX: begin
                state_d = MDS_IDLE;
                done_d  = 1'b1;
                dz_d    = 1'b0;
                if (!is_div) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (b_q == '0) begin
                    // Divide by zero: report the raw dividend, not a magnitude
                    hi_d = a_q;
                    lo_d = '1;
                    dz_d = 1'b1;
                end else begin
                    hi_d = rmd;
                    lo_d = quo;
                end
            end
            default: state_d = MDS_IDLE;
        endcase

        busy_d = (state_d != MDS_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MDS_IDLE;
            op_q    <= MD_MULTU;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: scoreboard of expected HI/LO/dz and
// completion cycle, pushed at issue and popped on each done pulse.
module tb_muldiv_seq;

    localparam int unsigned W = 32;
    localparam int unsigned LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .op_a  (op_a),
        .op_b  (op_b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int unsigned  due;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int unsigned  cyc = 0;
    int unsigned  checks = 0;
    int unsigned  failures = 0;
    logic [W-1:0] last_hi = '0;
    int           nbusy;
    logic [64:0]  m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: returns {dz, hi, lo}
    function automatic logic [64:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0]        p;
        logic signed [63:0] ps;
        logic signed [31:0] as_v;
        logic signed [31:0] bs_v;
        logic signed [31:0] qs;
        logic signed [31:0] rs;
        as_v = a;
        bs_v = b;
        case (o)
            2'b00: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            2'b01: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return {1'b0, ps};
            end
            2'b10: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
                qs = as_v / bs_v;
                rs = as_v % bs_v;
                return {1'b0, rs, qs};
            end
        endcase
    endfunction

    // Result monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            check_eq("busy_in_done", 64'(busy), 64'd0);
            if (sb.size() == 0) begin
                check_eq("spurious_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("hi", 64'(hi), 64'(mon_e.hi));
                check_eq("lo", 64'(lo), 64'(mon_e.lo));
                check_eq("dz", 64'(dz), 64'(mon_e.dz));
                check_eq("latency", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    // Drive a request at the current negedge; deassert at the next one
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic edz);
        exp_t e;
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        if (push) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.dz  = edz;
            e.due = cyc + LAT + 1;
            sb.push_back(e);
            last_hi = ehi;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting busy cycles on the way
    task automatic wait_done(output int nb);
        int n;
        n  = 0;
        nb = 0;
        while (!done && n < 200) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        if (!done) check_eq("timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                          output int nb);
        @(negedge clk);
        issue(o, a, b, 1'b1, ehi, elo, edz);
        wait_done(nb);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst = 1'b1; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_dz",   64'(dz),   64'd0);
        check_eq("rst_hi",   64'(hi),   64'd0);
        check_eq("rst_lo",   64'(lo),   64'd0);
        rst = 1'b0;

        // MTHI / MTLO while idle
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        check_eq("mthi", 64'(hi), 64'h1234);
        lo_we = 1'b1; wdata = 32'h0000_5678;
        @(negedge clk);
        lo_we = 1'b0;
        check_eq("mtlo", 64'(lo), 64'h5678);
        check_eq("mthi_hold", 64'(hi), 64'h1234);

        // Directed arithmetic cases
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, nbusy);
        check_eq("busy_cycles", 64'(nbusy), 64'(LAT));
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, nbusy);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, nbusy);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, nbusy);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, nbusy);
        run_op(2'b10, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, nbusy);
        run_op(2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, nbusy);
        run_op(2'b11, 32'hFFFF_FF00, 32'd0,         32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1, nbusy);

        // Random operations against the reference model
        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 4 == 1) rb = -rb;
            m = model(ro, ra, rb);
            run_op(ro, ra, rb, m[63:32], m[31:0], m[64], nbusy);
        end

        // Second start and MTHI during an operation are ignored
        @(negedge clk);
        issue(2'b00, 32'd1000, 32'd3, 1'b1, 32'd0, 32'd3000, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b10; op_a = 32'd5; op_b = 32'd0;
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check_eq("busy_write_ignored", 64'(hi), 64'(m[63:32]));
        wait_done(nbusy);

        // Back-to-back: new start in the done cycle
        run_op(2'b10, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, nbusy);
        issue(2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd4, 1'b0);
        wait_done(nbusy);
        check_eq("b2b_busy_cycles", 64'(nbusy), 64'(LAT));

        // Reset during RUN discards the operation
        @(negedge clk);
        issue(2'b00, 32'd77, 32'd77, 1'b0, '0, '0, 1'b0);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_done", 64'(done), 64'd0);
        check_eq("midrst_hi",   64'(hi),   64'd0);
        check_eq("midrst_lo",   64'(lo),   64'd0);
        check_eq("midrst_dz",   64'(dz),   64'd0);
        rst = 1'b0;
        repeat (LAT + 10) @(negedge clk);

        // Start together with MTLO on the same idle edge: result wins
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'h1111_1111;
        issue(2'b10, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
        lo_we = 1'b0;
        check_eq("start_mtlo_lo", 64'(lo), 64'h1111_1111);
        wait_done(nbusy);

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        check_eq("idle_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
